hazard_ctrl_sb: RTL and testbench

- Parametrised, scoreboarded successor to the pipeline hazard detector for the 5-stage RISC-V core.
- Sits beside the ID stage and generates stall/flush controls for PC, IF/ID, ID/EX, EX/MEM.
- Covers load-use hazards, N-source operands, and a pending-register scoreboard for long-latency units (MUL/DIV).
- Covers branch/jump redirect, including redirects that arrive while instruction fetch is waiting, and memory wait-state freezes.

---
 rtl/hazard_ctrl_sb_if.sv | 42 ++++
 rtl/hazard_ctrl_sb.sv | 109 ++++++++++
 tb/tb_hazard_ctrl_sb.sv | 119 +++++++++++
 3 files changed

// File: rtl/hazard_ctrl_sb_if.sv
// hazard_ctrl_sb_if: ID/EX/MEM hazard inputs and pipeline control outputs of hazard_ctrl_sb.
// master = pipeline side (drives hazard inputs), slave = hazard controller.
// HAZ_PERF_EN adds the stall_cycles / flush_events counters.
interface hazard_ctrl_sb_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5
);
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_rs_addr;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [REG_AW-1:0]         id_rd_addr;
  logic                      id_rd_we;
  logic                      id_long_op;
  logic                      ex_mem_read;
  logic [REG_AW-1:0]         ex_rd_addr;
  logic                      branch_taken;
  logic                      lop_done;
  logic [REG_AW-1:0]         lop_rd_addr;
  logic                      imem_wait;
  logic                      dmem_wait;
  logic                      pc_stall, if_stall, if_flush, id_stall, id_flush, ex_stall, mem_stall;
  logic                      lop_full;
`ifdef HAZ_PERF_EN
  logic [31:0]               stall_cycles, flush_events;
`endif
  modport master (
    output id_valid, id_rs_addr, id_rs_used, id_rd_addr, id_rd_we, id_long_op,
           ex_mem_read, ex_rd_addr, branch_taken, lop_done, lop_rd_addr, imem_wait, dmem_wait,
    input  pc_stall, if_stall, if_flush, id_stall, id_flush, ex_stall, mem_stall, lop_full
`ifdef HAZ_PERF_EN
    , input stall_cycles, flush_events
`endif
  );
  modport slave (
    input  id_valid, id_rs_addr, id_rs_used, id_rd_addr, id_rd_we, id_long_op,
           ex_mem_read, ex_rd_addr, branch_taken, lop_done, lop_rd_addr, imem_wait, dmem_wait,
    output pc_stall, if_stall, if_flush, id_stall, id_flush, ex_stall, mem_stall, lop_full
`ifdef HAZ_PERF_EN
    , output stall_cycles, flush_events
`endif
  );
endinterface

// File: rtl/hazard_ctrl_sb.sv
// hazard_ctrl_sb: stall/flush controller with long-op scoreboard for the 5-stage RISC-V pipeline.
// Ports: clk, rst_n (async active-low); hz (slave modport) carries ID/EX hazard inputs,
// branch/memory-wait inputs, the seven stall/flush controls and lop_full.
// Optional macro HAZ_PERF_EN adds saturating stall_cycles / flush_events counters.
module hazard_ctrl_sb #(
  parameter int NUM_SRC   = 2,
  parameter int REG_AW    = 5,
  parameter int LOP_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  hazard_ctrl_sb_if.slave hz
);
  localparam int NREG = 2 ** REG_AW;
  localparam int CW   = $clog2(LOP_DEPTH + 1);
  typedef enum logic {RUN, REDIRECT} state_t;
  state_t          state_q, state_d;
  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0]   lop_cnt_q, lop_cnt_d;
  logic            lop_full_q;
  logic            lu, raw, waw, strct, hz_c, issue, done_ok;
  // x0 sources are skipped, so a load or pending entry on x0 can never match
  always_comb begin
    lu  = 1'b0;
    raw = 1'b0;
    for (int k = 0; k < NUM_SRC; k++)
      if (hz.id_rs_used[k] && hz.id_rs_addr[k*REG_AW +: REG_AW] != '0) begin
        lu  = lu | (hz.ex_mem_read && hz.ex_rd_addr == hz.id_rs_addr[k*REG_AW +: REG_AW]);
        raw = raw | pend_q[hz.id_rs_addr[k*REG_AW +: REG_AW]];
      end
  end
  assign waw     = hz.id_rd_we && hz.id_rd_addr != '0 && pend_q[hz.id_rd_addr];
  assign strct   = hz.id_long_op && lop_cnt_q == CW'(LOP_DEPTH);
  assign hz_c    = hz.id_valid && (lu || raw || waw || strct);
  assign issue   = hz.id_valid && hz.id_long_op && hz.id_rd_we && !hz_c && !hz.dmem_wait &&
                   !hz.branch_taken && state_q == RUN;
  assign done_ok = hz.lop_done && lop_cnt_q != '0;
  // set is applied after clear so a same-register issue keeps the entry pending
  always_comb begin
    pend_d = pend_q;
    if (done_ok) pend_d[hz.lop_rd_addr] = 1'b0;
    if (issue && hz.id_rd_addr != '0) pend_d[hz.id_rd_addr] = 1'b1;
    lop_cnt_d = lop_cnt_q + CW'(issue) - CW'(done_ok);
  end
  always_comb begin
    state_d      = state_q;
    hz.pc_stall  = 1'b0;
    hz.if_stall  = 1'b0;
    hz.if_flush  = 1'b0;
    hz.id_stall  = 1'b0;
    hz.id_flush  = 1'b0;
    hz.ex_stall  = 1'b0;
    hz.mem_stall = 1'b0;
    if (!rst_n) begin
      state_d = RUN;
    end else if (hz.dmem_wait) begin
      hz.pc_stall  = 1'b1;
      hz.if_stall  = 1'b1;
      hz.id_stall  = 1'b1;
      hz.ex_stall  = 1'b1;
      hz.mem_stall = 1'b1;
    end else if (state_q == REDIRECT) begin
      // wrong-path fetch in flight: keep squashing until its word has arrived
      hz.if_flush = 1'b1;
      hz.pc_stall = hz.imem_wait;
      state_d     = hz.imem_wait ? REDIRECT : RUN;
    end else if (hz.branch_taken) begin
      hz.if_flush = 1'b1;
      hz.id_flush = 1'b1;
      state_d     = hz.imem_wait ? REDIRECT : RUN;
    end else if (hz_c) begin
      hz.pc_stall = 1'b1;
      hz.if_stall = 1'b1;
      hz.id_flush = 1'b1;
    end else if (hz.imem_wait) begin
      hz.pc_stall = 1'b1;
      hz.if_flush = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= RUN;
      pend_q     <= '0;
      lop_cnt_q  <= '0;
      lop_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      lop_cnt_q  <= lop_cnt_d;
      lop_full_q <= lop_cnt_d == CW'(LOP_DEPTH);
    end
  assign hz.lop_full = lop_full_q;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cycles_q, flush_events_q;
  logic        if_flush_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
      if_flush_q     <= 1'b0;
    end else begin
      if (hz.pc_stall && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (hz.if_flush && !if_flush_q && flush_events_q != '1) flush_events_q <= flush_events_q + 32'd1;
      if_flush_q <= hz.if_flush;
    end
  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_events = flush_events_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// tb_hazard_ctrl_sb: directed checks of hazard_ctrl_sb with LOP_DEPTH=2.
module tb_hazard_ctrl_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  hazard_ctrl_sb_if #(.NUM_SRC(2), .REG_AW(5)) bus ();
  hazard_ctrl_sb #(.NUM_SRC(2), .REG_AW(5), .LOP_DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .hz(bus.slave));
  always #5 clk = ~clk;
  // {pc_stall, if_stall, if_flush, id_stall, id_flush, ex_stall, mem_stall}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] FRZ  = 7'b1101011;
  localparam logic [6:0] BR   = 7'b0010100;
  localparam logic [6:0] HZ   = 7'b1100100;
  localparam logic [6:0] IW   = 7'b1010000;
  localparam logic [6:0] RDR  = 7'b0010000;
  wire [6:0] ctl = {bus.pc_stall, bus.if_stall, bus.if_flush, bus.id_stall, bus.id_flush, bus.ex_stall, bus.mem_stall};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    bus.id_valid = 0; bus.id_rs_addr = '0; bus.id_rs_used = '0; bus.id_rd_addr = '0;
    bus.id_rd_we = 0; bus.id_long_op = 0; bus.ex_mem_read = 0; bus.ex_rd_addr = '0;
    bus.branch_taken = 0; bus.lop_done = 0; bus.lop_rd_addr = '0; bus.imem_wait = 0; bus.dmem_wait = 0;
  endtask
  task automatic nxt();
    @(negedge clk);
  endtask
  task automatic src(input logic [4:0] a, input logic [4:0] b, input logic [1:0] used);
    bus.id_valid = 1; bus.id_rs_addr = {b, a}; bus.id_rs_used = used;
  endtask
  task automatic lop(input logic [4:0] rd);
    bus.id_valid = 1; bus.id_long_op = 1; bus.id_rd_we = 1; bus.id_rd_addr = rd;
  endtask
  task automatic done(input logic [4:0] rd);
    bus.lop_done = 1; bus.lop_rd_addr = rd;
  endtask
  initial begin
    idle();
    src(5, 0, 2'b01); bus.ex_mem_read = 1; bus.ex_rd_addr = 5;
    #1 chk("reset_ctl", ctl, NONE);
    chk("reset_full", bus.lop_full, 0);
    nxt(); rst_n = 1;
    #1 chk("lu_rs1", ctl, HZ);
    nxt(); src(0, 5, 2'b10);
    #1 chk("lu_rs2", ctl, HZ);
    bus.id_rs_used = 2'b01;
    #1 chk("lu_unused", ctl, NONE);
    nxt(); idle(); src(0, 0, 2'b11); bus.ex_mem_read = 1;
    #1 chk("lu_x0", ctl, NONE);
    nxt(); idle(); lop(7);
    #1 chk("issue_mul", ctl, NONE);
    nxt(); idle(); src(7, 0, 2'b01);
    for (int i = 1; i <= 3; i++) begin
      #1 chk("raw_wait", ctl, HZ);
      nxt();
    end
    done(7);
    #1 chk("raw_done_cycle", ctl, HZ);
    nxt(); bus.lop_done = 0;
    #1 chk("raw_release", ctl, NONE);
    nxt(); idle(); lop(8);
    #1 chk("issue_a", ctl, NONE);
    nxt(); lop(9);
    #1 chk("issue_b", ctl, NONE);
    nxt(); lop(10);
    #1 chk("lop_full", bus.lop_full, 1);
    chk("struct", ctl, HZ);
    bus.id_long_op = 0; bus.id_rd_addr = 8;
    #1 chk("waw", ctl, HZ);
    lop(10); done(8);
    #1 chk("struct_done_cycle", ctl, HZ);
    nxt(); bus.lop_done = 0;
    #1 chk("struct_issue", ctl, NONE);
    chk("full_dropped", bus.lop_full, 0);
    nxt(); idle();
    #1 chk("full_again", bus.lop_full, 1);
    done(9); nxt(); done(10); nxt();
    nxt(); bus.lop_done = 0;
    #1 chk("empty", bus.lop_full, 0);
    lop(20); nxt(); lop(21); nxt(); idle();
    #1 chk("no_underflow", bus.lop_full, 1);
    done(20); nxt(); done(21); nxt(); idle();
    bus.imem_wait = 1;
    #1 chk("imem", ctl, IW);
    nxt(); bus.branch_taken = 1;
    #1 chk("br_imem", ctl, BR);
    nxt(); bus.branch_taken = 0;
    #1 chk("rdr_wait1", ctl, IW);
    nxt();
    #1 chk("rdr_wait2", ctl, IW);
    nxt(); bus.imem_wait = 0;
    #1 chk("rdr_release", ctl, RDR);
    nxt();
    #1 chk("rdr_run", ctl, NONE);
    nxt(); src(5, 0, 2'b01); bus.ex_mem_read = 1; bus.ex_rd_addr = 5;
    bus.branch_taken = 1; bus.imem_wait = 1; bus.dmem_wait = 1;
    #1 chk("freeze", ctl, FRZ);
    nxt(); bus.dmem_wait = 0; bus.imem_wait = 0; bus.branch_taken = 0;
    #1 chk("freeze_no_redirect", ctl, HZ);
    bus.branch_taken = 1;
    #1 chk("branch_after_freeze", ctl, BR);
    nxt(); idle(); lop(3);
    nxt(); idle(); src(3, 0, 2'b01);
    #1 chk("raw_x3", ctl, HZ);
    #1 rst_n = 0;
    #1 chk("async_reset", ctl, NONE);
    @(posedge clk); #1 rst_n = 1;
    nxt();
    #1 chk("post_reset_x3", ctl, NONE);
    chk("post_reset_full", bus.lop_full, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
